// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, fixed 7-bit address match, byte-wide rx/tx fabric handshake.
// Optional build macro: I2C_GENERAL_CALL_EN (accept general-call address 0x00 for writes).

module i2c_target #(
    parameter logic [6:0]  ADDR       = 7'h50,
    parameter int unsigned FILTER_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX_BYTE,
        S_RX_ACK,
        S_TX_BYTE,
        S_TX_ACK,
        S_WAIT_STOP
    } state_t;

    logic [1:0]            scl_sync_q, sda_sync_q;
    logic [FILTER_LEN-1:0] scl_hist_q, sda_hist_q;
    logic                  scl_f_q, sda_f_q, scl_fp_q, sda_fp_q;

    // Synchroniser and glitch filter; reset to idle-bus levels so no edges appear after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_fp_q   <= 1'b1;
            sda_fp_q   <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl};
            sda_sync_q <= {sda_sync_q[0], i2c_sda};
            scl_hist_q <= FILTER_LEN'({scl_hist_q, scl_sync_q[1]});
            sda_hist_q <= FILTER_LEN'({sda_hist_q, sda_sync_q[1]});
            if (&scl_hist_q) begin
                scl_f_q <= 1'b1;
            end else if (~|scl_hist_q) begin
                scl_f_q <= 1'b0;
            end
            if (&sda_hist_q) begin
                sda_f_q <= 1'b1;
            end else if (~|sda_hist_q) begin
                sda_f_q <= 1'b0;
            end
            scl_fp_q <= scl_f_q;
            sda_fp_q <= sda_f_q;
        end
    end

    logic scl_rise_c, scl_fall_c, sda_rise_c, sda_fall_c, start_c, stop_c;

    assign scl_rise_c = scl_f_q & ~scl_fp_q;
    assign scl_fall_c = ~scl_f_q & scl_fp_q;
    assign sda_rise_c = sda_f_q & ~sda_fp_q;
    assign sda_fall_c = ~sda_f_q & sda_fp_q;
    assign start_c    = sda_fall_c & scl_f_q;
    assign stop_c     = sda_rise_c & scl_f_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic             ph_q, ph_d;
    logic             sda_low_q, sda_low_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_req_q, tx_req_d;
    logic             busy_q, busy_d;

    logic [7:0] byte_c;
    logic       own_hit_c, gc_hit_c;

    assign byte_c    = {shift_q, sda_f_q};
    assign own_hit_c = (byte_c[7:1] == ADDR);
`ifdef I2C_GENERAL_CALL_EN
    assign gc_hit_c  = (byte_c == 8'h00);
`else
    assign gc_hit_c  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            ph_q       <= 1'b0;
            sda_low_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ph_q       <= ph_d;
            sda_low_q  <= sda_low_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    // ph_q marks the second half of a multi-fall slot (ACK driven / last data bit sampled).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ph_d       = ph_q;
        sda_low_d  = sda_low_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;

        if (start_c) begin
            state_d   = S_ADDR;
            cnt_d     = '0;
            ph_d      = 1'b0;
            sda_low_d = 1'b0;
        end else if (stop_c) begin
            state_d   = S_IDLE;
            ph_d      = 1'b0;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sda_low_d = 1'b0;
                end
                S_ADDR: begin
                    if (scl_rise_c) begin
                        shift_d = byte_c[6:0];
                        if (cnt_q == CNT_W'(7)) begin
                            if (own_hit_c || gc_hit_c) begin
                                rw_d     = byte_c[0];
                                ph_d     = 1'b0;
                                tx_req_d = byte_c[0];
                                state_d  = S_ADDR_ACK;
                            end else begin
                                state_d  = S_WAIT_STOP;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall_c) begin
                        if (!ph_q) begin
                            sda_low_d = 1'b1;
                            ph_d      = 1'b1;
                        end else begin
                            ph_d  = 1'b0;
                            cnt_d = '0;
                            if (rw_q) begin
                                shift_d   = tx_data[6:0];
                                sda_low_d = ~tx_data[7];
                                state_d   = S_TX_BYTE;
                            end else begin
                                sda_low_d = 1'b0;
                                state_d   = S_RX_BYTE;
                            end
                        end
                    end
                end
                S_RX_BYTE: begin
                    if (scl_rise_c) begin
                        shift_d = byte_c[6:0];
                        if (cnt_q == CNT_W'(7)) begin
                            rx_data_d  = byte_c;
                            rx_valid_d = 1'b1;
                            ph_d       = 1'b0;
                            state_d    = S_RX_ACK;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall_c) begin
                        if (!ph_q) begin
                            sda_low_d = 1'b1;
                            ph_d      = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            ph_d      = 1'b0;
                            cnt_d     = '0;
                            state_d   = S_RX_BYTE;
                        end
                    end
                end
                S_TX_BYTE: begin
                    if (scl_rise_c) begin
                        if (cnt_q == CNT_W'(7)) begin
                            ph_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (scl_fall_c) begin
                        if (ph_q) begin
                            sda_low_d = 1'b0;
                            ph_d      = 1'b0;
                            state_d   = S_TX_ACK;
                        end else begin
                            sda_low_d = ~shift_q[6];
                            shift_d   = {shift_q[5:0], 1'b0};
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise_c) begin
                        if (sda_f_q) begin
                            state_d = S_WAIT_STOP;
                        end else begin
                            tx_req_d = 1'b1;
                        end
                    end else if (scl_fall_c) begin
                        shift_d   = tx_data[6:0];
                        sda_low_d = ~tx_data[7];
                        cnt_d     = '0;
                        state_d   = S_TX_BYTE;
                    end
                end
                S_WAIT_STOP: begin
                    sda_low_d = 1'b0;
                end
                default: begin
                    state_d   = S_IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == S_ADDR_ACK) || (state_d == S_RX_BYTE) || (state_d == S_RX_ACK) ||
                 (state_d == S_TX_BYTE)  || (state_d == S_TX_ACK);
    end

    assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged initiator, transaction table, rx/tx scoreboards.
// Honours I2C_GENERAL_CALL_EN to set the expected general-call response.

module tb_i2c_target;

    localparam int unsigned Q = 5;

`ifdef I2C_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl;
    logic       m_low;
    logic [7:0] tx_data = 8'hEE;
    logic       tx_req, rx_valid, busy;
    logic [7:0] rx_data;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(.ADDR(7'h50), .FILTER_LEN(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_scl  (m_scl),
        .i2c_sda  (sda),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboards: expected written bytes, and fabric bytes handed out on tx_req.
    logic [7:0] rx_exp[$];
    logic [7:0] tx_src[$];
    int rx_cnt = 0, tx_cnt = 0, tgt_low_cnt = 0, busy_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                rx_cnt++;
                if (rx_exp.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_data", int'(rx_data), int'(rx_exp.pop_front()));
            end
            if (tx_req) begin
                tx_cnt++;
                if (tx_src.size() > 0) tx_data = tx_src.pop_front();
            end
            if (rx_valid && tx_req) check("rx_tx_overlap", 1, 0);
            if (sda === 1'b0 && !m_low) tgt_low_cnt++;
            if (busy) busy_cnt++;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_x(input logic b, output logic rd);
        wait_clks(Q); m_low = ~b;
        wait_clks(Q); m_scl = 1'b1;
        wait_clks(Q); rd = sda;
        wait_clks(Q); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (!m_scl) begin
            wait_clks(Q); m_low = 1'b0;
            wait_clks(Q); m_scl = 1'b1;
        end
        wait_clks(Q); m_low = 1'b1;
        wait_clks(Q); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clks(Q); m_low = 1'b1;
        wait_clks(Q); m_scl = 1'b1;
        wait_clks(Q); m_low = 1'b0;
        wait_clks(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] v);
        logic r;
        v = '0;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            v[i] = r;
        end
        bit_x(~ack, r);
    endtask

    typedef struct {
        logic [7:0] addr;
        int         nbytes;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vec_t       t;
        logic       ack, is_rd;
        logic [7:0] got, want;
        int         rx0, tx0, low0, busy0;

        vecs[0] = '{8'hA0, 1, 8'hA5, 8'h00, 1'b1};
        vecs[1] = '{8'hA1, 1, 8'h3C, 8'h00, 1'b1};
        vecs[2] = '{8'hA1, 2, 8'h81, 8'h7E, 1'b1};
        vecs[3] = '{8'hA2, 1, 8'h55, 8'h00, 1'b0};
        vecs[4] = '{8'hA0, 2, 8'h00, 8'hFF, 1'b1};
        vecs[5] = '{8'h00, 1, 8'h5A, 8'h00, GC_EN};
        vecs[6] = '{8'h01, 1, 8'h99, 8'h00, 1'b0};
        vecs[7] = '{8'hA3, 1, 8'h77, 8'h00, 1'b0};

        rst = 1'b1; m_scl = 1'b1; m_low = 1'b0;
        wait_clks(3);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_tx_req", int'(tx_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sda_released", int'(sda === 1'b1), 1);
        rst = 1'b0;
        wait_clks(5);

        for (int v = 0; v < 8; v++) begin
            t = vecs[v];
            is_rd = t.addr[0];
            rx0 = rx_cnt; tx0 = tx_cnt; low0 = tgt_low_cnt; busy0 = busy_cnt;
            if (t.exp_ack) begin
                if (is_rd) begin
                    tx_src.push_back(t.d0);
                    if (t.nbytes > 1) tx_src.push_back(t.d1);
                end else begin
                    rx_exp.push_back(t.d0);
                    if (t.nbytes > 1) rx_exp.push_back(t.d1);
                end
            end
            i2c_start();
            write_byte(t.addr, ack);
            check($sformatf("v%0d_addr_ack", v), int'(ack), int'(t.exp_ack));
            if (is_rd) begin
                if (ack) begin
                    for (int i = 0; i < t.nbytes; i++) begin
                        read_byte(i < t.nbytes - 1, got);
                        want = (i == 0) ? t.d0 : t.d1;
                        check($sformatf("v%0d_rd_byte%0d", v, i), int'(got), int'(want));
                    end
                end
            end else begin
                for (int i = 0; i < t.nbytes; i++) begin
                    write_byte((i == 0) ? t.d0 : t.d1, ack);
                    check($sformatf("v%0d_wr_ack%0d", v, i), int'(ack), int'(t.exp_ack));
                end
            end
            i2c_stop();
            check($sformatf("v%0d_rx_pulses", v), rx_cnt - rx0,
                  (!is_rd && t.exp_ack) ? t.nbytes : 0);
            check($sformatf("v%0d_tx_pulses", v), tx_cnt - tx0,
                  (is_rd && t.exp_ack) ? t.nbytes : 0);
            check($sformatf("v%0d_target_drove", v), int'(tgt_low_cnt > low0), int'(t.exp_ack));
            check($sformatf("v%0d_busy_seen", v), int'(busy_cnt > busy0), int'(t.exp_ack));
            check($sformatf("v%0d_busy_idle", v), int'(busy), 0);
            check($sformatf("v%0d_sda_released", v), int'(sda === 1'b1), 1);
            if (!is_rd && t.exp_ack)
                check($sformatf("v%0d_rx_hold", v), int'(rx_data),
                      int'((t.nbytes > 1) ? t.d1 : t.d0));
        end

        // Partial byte abandoned by a repeated START must not be delivered.
        rx0 = rx_cnt;
        rx_exp.push_back(8'h11);
        i2c_start();
        write_byte(8'hA0, ack);
        check("rs_first_addr_ack", int'(ack), 1);
        bit_x(1'b1, ack); bit_x(1'b0, ack); bit_x(1'b1, ack); bit_x(1'b0, ack);
        i2c_start();
        write_byte(8'hA0, ack);
        check("rs_second_addr_ack", int'(ack), 1);
        write_byte(8'h11, ack);
        check("rs_data_ack", int'(ack), 1);
        i2c_stop();
        check("rs_rx_pulses", rx_cnt - rx0, 1);
        check("rs_rx_data", int'(rx_data), 8'h11);

        // Reset asserted while the target holds the address ACK low.
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            got = 8'hA0;
            bit_x(got[i], ack);
        end
        wait_clks(Q); m_low = 1'b0;
        wait_clks(Q); m_scl = 1'b1;
        wait_clks(2);
        check("ack_slot_sda_low", int'(sda === 1'b0), 1);
        check("ack_slot_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_sda_released", int'(sda === 1'b1), 1);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_rx_data", int'(rx_data), 0);
        check("rst_mid_rx_valid", int'(rx_valid), 0);
        check("rst_mid_tx_req", int'(tx_req), 0);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(Q);
        m_scl = 1'b0;
        i2c_stop();

        // Target must recover cleanly after the mid-transfer reset.
        rx0 = rx_cnt;
        rx_exp.push_back(8'h42);
        i2c_start();
        write_byte(8'hA0, ack);
        check("post_rst_addr_ack", int'(ack), 1);
        write_byte(8'h42, ack);
        check("post_rst_data_ack", int'(ack), 1);
        i2c_stop();
        check("post_rst_rx_pulses", rx_cnt - rx0, 1);

        check("rx_scoreboard_empty", rx_exp.size(), 0);
        check("tx_scoreboard_empty", tx_src.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
